multicycle_ctrl: RTL and testbench

//   Main control FSM that sequences the multicycle MIPS-subset datapath (Datapath2).

---
 rtl/multicycle_ctrl_if.sv | 36 +++
 rtl/multicycle_ctrl.sv | 167 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle main controller and the Datapath2 datapath.
// The controller side drives every select/enable and the debug state; the datapath side returns opcode and memory handshake.
interface multicycle_ctrl_if #(
  parameter int unsigned STATE_W  = 4,
  parameter int unsigned OPCODE_W = 6
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;

  logic                IorD;
  logic                MemWrite;
  logic                IRWrite;
  logic                PCWrite;
  logic                Branch;
  logic                RegDst;
  logic                MemtoReg;
  logic                RegWrite;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [1:0]          ALUOp;
  logic [1:0]          PCSrc;
  logic [STATE_W-1:0]  state;
  logic                halted;

  modport master (
    input  opcode, mem_ready,
    output IorD, MemWrite, IRWrite, PCWrite, Branch, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, state, halted
  );

  modport slave (
    output opcode, mem_ready,
    input  IorD, MemWrite, IRWrite, PCWrite, Branch, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, state, halted
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS-subset datapath.
// Sequences fetch/decode/execute, stalls on mem_ready, halts on an unsupported opcode.
module multicycle_ctrl #(
  parameter int unsigned STATE_W  = 4,
  parameter int unsigned OPCODE_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_ctrl_if.master     bus
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = STATE_W'(0),
    S_DECODE  = STATE_W'(1),
    S_MEMADR  = STATE_W'(2),
    S_MEMRD   = STATE_W'(3),
    S_MEMWB   = STATE_W'(4),
    S_MEMWR   = STATE_W'(5),
    S_RTYPEEX = STATE_W'(6),
    S_RTYPEWB = STATE_W'(7),
    S_BEQEX   = STATE_W'(8),
    S_ADDIEX  = STATE_W'(9),
    S_ADDIWB  = STATE_W'(10),
    S_JEX     = STATE_W'(11),
    S_HALT    = STATE_W'(12)
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);

  state_t r_state;

  logic       w_iord;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_regdst;
  logic       w_memtoreg;
  logic       w_regwrite;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_aluop;
  logic [1:0] w_pcsrc;

  // State sequencing; unused codes 13-15 recover to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:   if (bus.mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (bus.opcode)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_R:         r_state <= S_RTYPEEX;
            OP_BEQ:       r_state <= S_BEQEX;
            OP_ADDI:      r_state <= S_ADDIEX;
            OP_J:         r_state <= S_JEX;
            default:      r_state <= S_HALT;
          endcase
        end
        S_MEMADR:  r_state <= (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   if (bus.mem_ready) r_state <= S_MEMWB;
        S_MEMWR:   if (bus.mem_ready) r_state <= S_FETCH;
        S_MEMWB:   r_state <= S_FETCH;
        S_RTYPEEX: r_state <= S_RTYPEWB;
        S_RTYPEWB: r_state <= S_FETCH;
        S_BEQEX:   r_state <= S_FETCH;
        S_ADDIEX:  r_state <= S_ADDIWB;
        S_ADDIWB:  r_state <= S_FETCH;
        S_JEX:     r_state <= S_FETCH;
        S_HALT:    r_state <= S_HALT;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  // Control decode from state; FETCH load enables are gated by mem_ready.
  always_comb begin
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_aluop    = 2'b00;
    w_pcsrc    = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_alusrcb = 2'b01;
        w_irwrite = bus.mem_ready;
        w_pcwrite = bus.mem_ready;
      end
      S_DECODE:  w_alusrcb = 2'b11;
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_MEMRD:   w_iord = 1'b1;
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
      end
      S_RTYPEWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BEQEX: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b01;
        w_pcsrc   = 2'b01;
        w_branch  = 1'b1;
      end
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_ADDIWB:  w_regwrite = 1'b1;
      S_JEX: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: ;
    endcase
    // Reset must suppress every write even though FETCH would otherwise follow mem_ready.
    if (reset) begin
      w_irwrite  = 1'b0;
      w_pcwrite  = 1'b0;
      w_memwrite = 1'b0;
      w_regwrite = 1'b0;
      w_branch   = 1'b0;
    end
  end

  assign bus.IorD     = w_iord;
  assign bus.MemWrite = w_memwrite;
  assign bus.IRWrite  = w_irwrite;
  assign bus.PCWrite  = w_pcwrite;
  assign bus.Branch   = w_branch;
  assign bus.RegDst   = w_regdst;
  assign bus.MemtoReg = w_memtoreg;
  assign bus.RegWrite = w_regwrite;
  assign bus.ALUSrcA  = w_alusrca;
  assign bus.ALUSrcB  = w_alusrcb;
  assign bus.ALUOp    = w_aluop;
  assign bus.PCSrc    = w_pcsrc;
  assign bus.state    = r_state;
  assign bus.halted   = (r_state == S_HALT);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a vector table replayed through a scoreboard queue,
// plus hand-written reset sequences (out of HALT and in the middle of a stalled store).
module tb_multicycle_ctrl;

  logic clk;
  logic reset;

  multicycle_ctrl_if #(.STATE_W(4), .OPCODE_W(6)) bus ();

  multicycle_ctrl #(.STATE_W(4), .OPCODE_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [15:0] cw;
  } vec_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  int checks = 0;
  int errors = 0;

  vec_t tbl[$];
  vec_t sb[$];

  // Control word packing: {IorD,MemWrite,IRWrite,PCWrite,Branch,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc,halted}
  function automatic logic [15:0] cw(input logic iord, input logic mw, input logic irw,
                                     input logic pcw, input logic br, input logic rd,
                                     input logic mtr, input logic rw, input logic sa,
                                     input logic [1:0] sb_, input logic [1:0] ao,
                                     input logic [1:0] ps, input logic h);
    return {iord, mw, irw, pcw, br, rd, mtr, rw, sa, sb_, ao, ps, h};
  endfunction

  function automatic logic [15:0] dut_cw();
    return {bus.IorD, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.Branch, bus.RegDst,
            bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSrc,
            bus.halted};
  endfunction

  logic [15:0] F_RDY, F_NRDY, DEC, MADR, MRD, MWB, MWR, REX, RWB, BEQ, AEX, AWB, JEX, HLT;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic rdy, input int st, input logic [15:0] c);
    vec_t v;
    v.op = op; v.rdy = rdy; v.st = 4'(st); v.cw = c;
    tbl.push_back(v);
  endtask

  // Drive one cycle of stimulus and queue what the DUT must show during that cycle.
  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    bus.opcode    = v.op;
    bus.mem_ready = v.rdy;
    sb.push_back(v);
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest queued expectation.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      vec_t e;
      e = sb.pop_front();
      chk($sformatf("state op=%b rdy=%b", e.op, e.rdy), 16'(bus.state), 16'(e.st));
      chk($sformatf("ctrl st=%0d rdy=%b", e.st, e.rdy), dut_cw(), e.cw);
    end
  end

  initial begin
    vec_t v;
    F_RDY  = cw(0,0,1,1,0,0,0,0,0,2'b01,2'b00,2'b00,0);
    F_NRDY = cw(0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
    DEC    = cw(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
    MADR   = cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    MRD    = cw(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    MWB    = cw(0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0);
    MWR    = cw(1,1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    REX    = cw(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
    RWB    = cw(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
    BEQ    = cw(0,0,0,0,1,0,0,0,1,2'b00,2'b01,2'b01,0);
    AEX    = cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    AWB    = cw(0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);
    JEX    = cw(0,0,0,1,0,0,0,0,0,2'b00,2'b00,2'b10,0);
    HLT    = cw(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1);

    // lw, sw, R-type with memory always ready
    add(OP_LW,1,0,F_RDY); add(OP_LW,1,1,DEC); add(OP_LW,1,2,MADR); add(OP_LW,1,3,MRD); add(OP_LW,1,4,MWB);
    add(OP_SW,1,0,F_RDY); add(OP_SW,1,1,DEC); add(OP_SW,1,2,MADR); add(OP_SW,1,5,MWR);
    add(OP_R,1,0,F_RDY);  add(OP_R,1,1,DEC);  add(OP_R,1,6,REX);   add(OP_R,1,7,RWB);
    // fetch stalled three cycles, then addi
    for (int i = 0; i < 3; i++) add(OP_ADDI,0,0,F_NRDY);
    add(OP_ADDI,1,0,F_RDY); add(OP_ADDI,1,1,DEC); add(OP_ADDI,1,9,AEX); add(OP_ADDI,1,10,AWB);
    // beq, j
    add(OP_BEQ,1,0,F_RDY); add(OP_BEQ,1,1,DEC); add(OP_BEQ,1,8,BEQ);
    add(OP_J,1,0,F_RDY);   add(OP_J,1,1,DEC);   add(OP_J,1,11,JEX);
    // lw with read stall, sw with write stall
    add(OP_LW,1,0,F_RDY); add(OP_LW,1,1,DEC); add(OP_LW,1,2,MADR);
    add(OP_LW,0,3,MRD);   add(OP_LW,0,3,MRD); add(OP_LW,1,3,MRD); add(OP_LW,1,4,MWB);
    add(OP_SW,1,0,F_RDY); add(OP_SW,1,1,DEC); add(OP_SW,1,2,MADR);
    add(OP_SW,0,5,MWR);   add(OP_SW,1,5,MWR);
    // illegal opcode halts and ignores mem_ready
    add(OP_BAD,1,0,F_RDY); add(OP_BAD,1,1,DEC);
    for (int i = 0; i < 11; i++) add(OP_BAD, 1'(i % 2), 12, HLT);

    // reset state, with mem_ready high to prove enables are forced off
    reset = 1'b1;
    bus.opcode = OP_LW;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_state", 16'(bus.state), 16'd0);
    chk("reset_ctrl", dut_cw(), F_NRDY);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
    @(negedge clk);

    // reset out of HALT
    #1;
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    chk("halt_reset_state", 16'(bus.state), 16'd0);
    chk("halt_reset_ctrl", dut_cw(), F_NRDY);
    @(posedge clk);
    #2;
    bus.mem_ready = 1'b0;
    reset = 1'b0;

    // reset asserted while a store waits for acceptance
    v.op = OP_SW; v.rdy = 1'b1; v.st = 4'd0; v.cw = F_RDY; step(v);
    v.st = 4'd1; v.cw = DEC;  step(v);
    v.st = 4'd2; v.cw = MADR; step(v);
    v.rdy = 1'b0; v.st = 4'd5; v.cw = MWR; step(v);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("memwr_reset_state", 16'(bus.state), 16'd0);
    chk("memwr_reset_memwrite", 16'(bus.MemWrite), 16'd0);
    chk("memwr_reset_ctrl", dut_cw(), F_NRDY);
    @(posedge clk);
    #2;
    reset = 1'b0;

    // normal operation resumes with an R-type
    v.op = OP_R; v.rdy = 1'b1; v.st = 4'd0; v.cw = F_RDY; step(v);
    v.st = 4'd1; v.cw = DEC; step(v);
    v.st = 4'd6; v.cw = REX; step(v);
    v.st = 4'd7; v.cw = RWB; step(v);
    v.op = OP_J; v.st = 4'd0; v.cw = F_RDY; step(v);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 16'(sb.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
